uc_multiciclo: RTL and testbench

Multi-cycle control unit for the RV32I core. It sequences a shared-memory, multi-cycle datapath (single ALU, instruction register, single instruction/data memory port) through fetch, decode, execute, memory and writeback states. It drives every datapath mux select and write enable, and handshakes with the memory port through `mem_req`/`mem_ready`. It sits beside the datapath inside the processor top level and replaces the single-cycle decoder when the multi-cycle build is selected.

---
 rtl/uc_multiciclo_if.sv | 41 ++++
 rtl/uc_multiciclo.sv | 191 +++++++++++++++++++
 tb/tb_uc_multiciclo.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/uc_multiciclo_if.sv
// Bundle of the signals exchanged between the multi-cycle control unit and
// its datapath: instruction fields, flags, memory handshake and all controls.
interface uc_multiciclo_if #(
  parameter int INSTRET_W = 32
);
  logic [6:0]           op;
  logic [2:0]           f3;
  logic                 f7b5;
  logic                 zero;
  logic                 mem_ready;
  logic                 mem_req;
  logic                 PCWrite;
  logic                 AdrSrc;
  logic                 IRWrite;
  logic                 MemWrite;
  logic                 RegWrite;
  logic [1:0]           ResultSrc;
  logic [1:0]           ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ImmSrc;
  logic [2:0]           ALUControl;
  logic                 illegal_op;
  logic [3:0]           state;
  logic [INSTRET_W-1:0] instret;

  // Control unit side: consumes instruction fields and flags, drives controls
  modport master (
    input  op, f3, f7b5, zero, mem_ready,
    output mem_req, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
           illegal_op, state, instret
  );

  // Datapath side: the mirror image of the control unit
  modport slave (
    output op, f3, f7b5, zero, mem_ready,
    input  mem_req, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
           illegal_op, state, instret
  );
endinterface

// File: rtl/uc_multiciclo.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/memory/
// writeback over a shared memory port and counts retired instructions.
// All controls are combinational from the current state and the inputs.
module uc_multiciclo #(
  parameter int INSTRET_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  uc_multiciclo_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t               r_state;
  state_t               w_next;
  logic [INSTRET_W-1:0] r_instret;
  logic [2:0]           w_aluDec;
  logic                 w_branchTaken;
  logic                 w_retire;

  // ALU operation for register and immediate arithmetic, chosen by funct3
  always_comb begin
    w_aluDec = ALU_ADD;
    case (bus.f3)
      3'b000:  w_aluDec = (bus.op[5] && bus.f7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  w_aluDec = ALU_SLT;
      3'b100:  w_aluDec = ALU_XOR;
      3'b110:  w_aluDec = ALU_OR;
      3'b111:  w_aluDec = ALU_AND;
      default: w_aluDec = ALU_ADD;
    endcase
  end

  // Immediate format depends only on the opcode, whatever the state
  always_comb begin
    bus.ImmSrc = 2'b00;
    case (bus.op)
      OP_SW:     bus.ImmSrc = 2'b01;
      OP_BRANCH: bus.ImmSrc = 2'b10;
      OP_JAL:    bus.ImmSrc = 2'b11;
      default:   bus.ImmSrc = 2'b00;
    endcase
  end

  assign w_branchTaken = ((bus.f3 == 3'b000) &&  bus.zero) ||
                         ((bus.f3 == 3'b001) && !bus.zero);

  // Next-state and control decode; reset forces the idle FETCH controls
  always_comb begin
    w_next         = r_state;
    bus.mem_req    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ALUControl = ALU_ADD;
    bus.illegal_op = 1'b0;
    if (!rst_n) begin
      w_next        = FETCH;
      bus.ALUSrcB   = 2'b10;
      bus.ResultSrc = 2'b10;
    end else begin
      case (r_state)
        FETCH: begin
          bus.mem_req   = 1'b1;
          bus.ALUSrcB   = 2'b10;
          bus.ResultSrc = 2'b10;
          if (bus.mem_ready) begin
            bus.IRWrite = 1'b1;
            bus.PCWrite = 1'b1;
            w_next      = DECODE;
          end
        end
        DECODE: begin
          bus.ALUSrcA = 2'b01;
          bus.ALUSrcB = 2'b01;
          case (bus.op)
            OP_LW, OP_SW: w_next = MEMADR;
            OP_R:         w_next = EXECR;
            OP_I:         w_next = EXECI;
            OP_BRANCH:    w_next = BRANCH;
            OP_JAL:       w_next = JAL;
            default: begin
              bus.illegal_op = 1'b1;
              w_next         = FETCH;
            end
          endcase
        end
        MEMADR: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUSrcB = 2'b01;
          w_next      = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
        end
        MEMREAD: begin
          bus.mem_req = 1'b1;
          bus.AdrSrc  = 1'b1;
          if (bus.mem_ready) w_next = MEMWB;
        end
        MEMWB: begin
          bus.ResultSrc = 2'b01;
          bus.RegWrite  = 1'b1;
          w_next        = FETCH;
        end
        MEMWRITE: begin
          bus.mem_req  = 1'b1;
          bus.MemWrite = 1'b1;
          bus.AdrSrc   = 1'b1;
          if (bus.mem_ready) w_next = FETCH;
        end
        EXECR: begin
          bus.ALUSrcA    = 2'b10;
          bus.ALUControl = w_aluDec;
          w_next         = ALUWB;
        end
        EXECI: begin
          bus.ALUSrcA    = 2'b10;
          bus.ALUSrcB    = 2'b01;
          bus.ALUControl = w_aluDec;
          w_next         = ALUWB;
        end
        ALUWB: begin
          bus.RegWrite = 1'b1;
          w_next       = FETCH;
        end
        BRANCH: begin
          bus.ALUSrcA    = 2'b10;
          bus.ALUControl = ALU_SUB;
          bus.PCWrite    = w_branchTaken;
          w_next         = FETCH;
        end
        JAL: begin
          bus.ALUSrcA = 2'b01;
          bus.ALUSrcB = 2'b10;
          bus.PCWrite = 1'b1;
          w_next      = ALUWB;
        end
        default: w_next = FETCH;
      endcase
    end
  end

  // An instruction retires when its last state hands control back to FETCH
  assign w_retire = (w_next == FETCH) &&
                    ((r_state == MEMWB) || (r_state == MEMWRITE) ||
                     (r_state == ALUWB) || (r_state == BRANCH));

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instret <= r_instret + 1'b1;
    end
  end

  assign bus.state   = r_state;
  assign bus.instret = r_instret;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Self-checking bench for uc_multiciclo: directed scenarios plus random
// instruction streams compared against a per-instruction cycle-script model.
module tb_uc_multiciclo;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   expRet;

  uc_multiciclo_if #(.INSTRET_W(32)) bus ();

  uc_multiciclo #(.INSTRET_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       req;
    logic       pcw;
    logic       irw;
    logic       mw;
    logic       rw;
    logic       adr;
    logic       ill;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] alu;
  } exp_t;

  // Build one expected cycle record
  function automatic exp_t ex(input logic [3:0] st, input logic req, pcw, irw,
                              mw, rw, adr, ill, input logic [1:0] rs, sa, sb,
                              input logic [2:0] alu);
    exp_t e;
    e = '{st, req, pcw, irw, mw, rw, adr, ill, rs, sa, sb, alu};
    return e;
  endfunction

  // Immediate format expected for an opcode
  function automatic logic [1:0] immOf(input logic [6:0] op);
    if (op == 7'b0100011) return 2'b01;
    if (op == 7'b1100011) return 2'b10;
    if (op == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  // ALU operation for arithmetic instructions
  function automatic logic [2:0] aluOf(input logic [6:0] op, input logic [2:0] f3,
                                       input logic f7b5);
    case (f3)
      3'd0:    return (op == 7'b0110011 && f7b5) ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd4:    return 3'b100;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o = '{bus.state, bus.mem_req, bus.PCWrite, bus.IRWrite, bus.MemWrite,
          bus.RegWrite, bus.AdrSrc, bus.illegal_op, bus.ResultSrc,
          bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl};
    return o;
  endfunction

  // Compare the state and the full control vector of the current cycle
  task automatic checkOutput(input string tag, input exp_t e);
    exp_t o;
    o = observed();
    checks++;
    assert (o.st === e.st) else begin
      errors++;
      $error("[TB] FAIL %s state: got %0d expected %0d", tag, o.st, e.st);
    end
    checks++;
    assert (o === e) else begin
      errors++;
      $error("[TB] FAIL %s controls: got %h expected %h", tag, o, e);
    end
    checks++;
    assert (bus.ImmSrc === immOf(bus.op)) else begin
      errors++;
      $error("[TB] FAIL %s ImmSrc: got %b expected %b", tag, bus.ImmSrc, immOf(bus.op));
    end
  endtask

  // Drive one cycle of mem_ready, check, then advance to just after the edge
  task automatic applyStimulus(input string tag, input exp_t e, input logic rdy);
    bus.mem_ready = rdy;
    #1;
    checkOutput(tag, e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkInstret(input string tag);
    checks++;
    assert (bus.instret === 32'(expRet)) else begin
      errors++;
      $error("[TB] FAIL %s instret: got %0d expected %0d", tag, bus.instret, expRet);
    end
  endtask

  // Cycle script of one instruction from FETCH back to FETCH
  task automatic runInstr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic f7b5, input logic zero, input int fw, input int mw);
    logic ill;
    logic take;
    bus.op = op; bus.f3 = f3; bus.f7b5 = f7b5; bus.zero = zero;
    ill = !(op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                       7'b1100011, 7'b1101111});
    for (int i = 0; i < fw; i++)
      applyStimulus(tag, ex(0,1,0,0,0,0,0,0,2'b10,2'b00,2'b10,3'b000), 1'b0);
    applyStimulus(tag, ex(0,1,1,1,0,0,0,0,2'b10,2'b00,2'b10,3'b000), 1'b1);
    applyStimulus(tag, ex(1,0,0,0,0,0,0,ill,2'b00,2'b01,2'b01,3'b000), 1'($urandom));
    if (op == 7'b0000011 || op == 7'b0100011)
      applyStimulus(tag, ex(2,0,0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000), 1'($urandom));
    case (op)
      7'b0000011: begin
        for (int i = 0; i < mw; i++)
          applyStimulus(tag, ex(3,1,0,0,0,0,1,0,2'b00,2'b00,2'b00,3'b000), 1'b0);
        applyStimulus(tag, ex(3,1,0,0,0,0,1,0,2'b00,2'b00,2'b00,3'b000), 1'b1);
        applyStimulus(tag, ex(4,0,0,0,0,1,0,0,2'b01,2'b00,2'b00,3'b000), 1'($urandom));
        expRet++;
      end
      7'b0100011: begin
        for (int i = 0; i < mw; i++)
          applyStimulus(tag, ex(5,1,0,0,1,0,1,0,2'b00,2'b00,2'b00,3'b000), 1'b0);
        applyStimulus(tag, ex(5,1,0,0,1,0,1,0,2'b00,2'b00,2'b00,3'b000), 1'b1);
        expRet++;
      end
      7'b0110011, 7'b0010011: begin
        applyStimulus(tag, ex((op == 7'b0110011) ? 4'd6 : 4'd7,0,0,0,0,0,0,0,2'b00,2'b10,
                              (op == 7'b0110011) ? 2'b00 : 2'b01, aluOf(op,f3,f7b5)),
                      1'($urandom));
        applyStimulus(tag, ex(8,0,0,0,0,1,0,0,2'b00,2'b00,2'b00,3'b000), 1'($urandom));
        expRet++;
      end
      7'b1100011: begin
        take = (f3 == 3'd0) ? zero : ((f3 == 3'd1) ? !zero : 1'b0);
        applyStimulus(tag, ex(9,0,take,0,0,0,0,0,2'b00,2'b10,2'b00,3'b001), 1'($urandom));
        expRet++;
      end
      7'b1101111: begin
        applyStimulus(tag, ex(10,0,1,0,0,0,0,0,2'b00,2'b01,2'b10,3'b000), 1'($urandom));
        applyStimulus(tag, ex(8,0,0,0,0,1,0,0,2'b00,2'b00,2'b00,3'b000), 1'($urandom));
        expRet++;
      end
      default: ;
    endcase
    checkInstret(tag);
  endtask

  initial begin
    logic [6:0] opList [8];
    logic [6:0] rop;
    checks = 0;
    errors = 0;
    expRet = 0;
    opList = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
               7'b1100011, 7'b1101111, 7'b0000000, 7'b1110011};
    bus.op = 7'b0; bus.f3 = 3'b0; bus.f7b5 = 1'b0; bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    rst_n = 1'b0;

    // Reset held two cycles with mem_ready high: enables quiet, FETCH selects
    @(posedge clk); @(posedge clk); #1;
    checkOutput("reset", ex(0,0,0,0,0,0,0,0,2'b10,2'b00,2'b10,3'b000));
    checkInstret("reset");
    rst_n = 1'b1;

    // Directed scenarios
    runInstr("add", 7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);
    runInstr("sub", 7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);
    runInstr("lw_wait2", 7'b0000011, 3'b010, 1'b0, 1'b0, 2, 2);
    runInstr("sw", 7'b0100011, 3'b010, 1'b0, 1'b0, 0, 1);
    runInstr("beq_taken", 7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);
    runInstr("bne_nottaken", 7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0);
    runInstr("illegal", 7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0);
    runInstr("jal", 7'b1101111, 3'b000, 1'b0, 1'b0, 1, 0);
    runInstr("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0);

    // Random instruction stream with random waits and flags
    for (int n = 0; n < 60; n++) begin
      rop = opList[$urandom_range(0, 7)];
      runInstr("random", rop, 3'($urandom), 1'($urandom), 1'($urandom),
               $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset in the middle of a store wait abandons the access
    bus.op = 7'b0100011; bus.f3 = 3'b010;
    applyStimulus("rst_mid", ex(0,1,1,1,0,0,0,0,2'b10,2'b00,2'b10,3'b000), 1'b1);
    applyStimulus("rst_mid", ex(1,0,0,0,0,0,0,0,2'b00,2'b01,2'b01,3'b000), 1'b0);
    applyStimulus("rst_mid", ex(2,0,0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000), 1'b0);
    bus.mem_ready = 1'b0;
    #1;
    checkOutput("rst_mid_wait", ex(5,1,0,0,1,0,1,0,2'b00,2'b00,2'b00,3'b000));
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_drop", ex(5,0,0,0,0,0,0,0,2'b10,2'b00,2'b10,3'b000));
    @(posedge clk); #1;
    expRet = 0;
    checkOutput("rst_mid_after", ex(0,0,0,0,0,0,0,0,2'b10,2'b00,2'b10,3'b000));
    checkInstret("rst_mid_after");
    rst_n = 1'b1;
    runInstr("post_reset", 7'b0010011, 3'b111, 1'b0, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
